ball_scheduler: RTL and testbench

Frame-rate sequencer that owns the position, direction, speed and divider state of all balls and updates them once per frame through one shared step datapath, serialised ball by ball. It sits between the VGA timing generator and the pixel painter:
- It is triggered by a one-cycle `frame_start` pulse at the start of vertical blanking.
- It publishes the ball coordinates, in 4-pixel units, for the painter to read during the active area.

---
 rtl/ball_scheduler_pkg.sv | 41 ++++
 rtl/ball_step.sv | 52 +++++
 rtl/ball_scheduler.sv | 132 +++++++++++++
 tb/tb_ball_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ball_scheduler_pkg.sv
// Shared definitions for the ball sequencer: playfield size in 4-pixel units,
// scan FSM encoding, the per-ball state record and the start formation.
package ball_scheduler_pkg;

   localparam int HPIXELS_4 = 160;
   localparam int VPIXELS_4 = 120;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_COMMIT = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   // Mutable state of one ball. dir_x: 1 = right, dir_y: 1 = down.
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic       dir_x;
      logic       dir_y;
      logic [1:0] div;
   } ball_t;

   // Start formation: a horizontal row centred on the screen, directions
   // taken from the two low bits of the ball index.
   function automatic ball_t ball_reset(int balls, int i);
      ball_t b;
      b.x     = 8'(HPIXELS_4 / 2 - balls + 2 * i);
      b.y     = 8'(VPIXELS_4 / 2);
      b.dir_x = 1'((i >> 1) & 1);
      b.dir_y = 1'(i & 1);
      b.div   = 2'd0;
      return b;
   endfunction

   // Frame divider reload value; a ball moves every speed+1 frames.
   function automatic logic [1:0] speed_of(int i);
      return 2'(i % 4);
   endfunction

endpackage

// File: rtl/ball_step.sv
// One frame step for a single ball: advance the frame divider and, when it
// wraps, bounce off the walls and move one unit. Shared by all balls.
module ball_step
   import ball_scheduler_pkg::*;
(
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       dir_x,
   input  logic       dir_y,
   input  logic [1:0] speed,
   input  logic [1:0] div,
   input  logic [5:0] wt,
   output logic [7:0] next_x,
   output logic [7:0] next_y,
   output logic       next_dir_x,
   output logic       next_dir_y,
   output logic [1:0] next_div
);

   logic [7:0] wt_ext;
   logic [7:0] lo_lim;
   logic [7:0] x_hi_lim;
   logic [7:0] y_hi_lim;

   // wt <= 63 keeps the far limits positive, so plain 8-bit math suffices.
   assign wt_ext   = {2'b00, wt};
   assign lo_lim   = wt_ext + 8'd1;
   assign x_hi_lim = 8'(HPIXELS_4 - 1) - wt_ext;
   assign y_hi_lim = 8'(VPIXELS_4 - 1) - wt_ext;

   // Divider advance, then direction flip and unit move on wrap.
   // NOTE: every output gets a default first so no path leaves a latch.
   always_comb begin
      next_x     = x;
      next_y     = y;
      next_dir_x = dir_x;
      next_dir_y = dir_y;
      next_div   = div + 2'd1;
      if (div == speed) begin
         next_div = 2'd0;
         // Each flip is gated by the current direction, so the near and far
         // wall tests can never both fire for the same axis.
         if (!dir_x && (x < lo_lim))   next_dir_x = 1'b1;
         if (dir_x  && (x >= x_hi_lim)) next_dir_x = 1'b0;
         if (!dir_y && (y < lo_lim))   next_dir_y = 1'b1;
         if (dir_y  && (y >= y_hi_lim)) next_dir_y = 1'b0;
         next_x = next_dir_x ? x + 8'd1 : x - 8'd1;
         next_y = next_dir_y ? y + 8'd1 : y - 8'd1;
      end
   end

endmodule

// File: rtl/ball_scheduler.sv
// Frame-rate sequencer: on each accepted frame_start, walks every ball
// through the shared step datapath (FETCH then COMMIT per ball) and
// publishes the coordinates straight from the state registers.
module ball_scheduler
   import ball_scheduler_pkg::*;
#(
   parameter int BALLS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 frame_start,
   input  logic                 run,
   input  logic [5:0]           wall_thickness_4,
   output logic [8*BALLS-1:0]   ball_x,
   output logic [8*BALLS-1:0]   ball_y,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun
);

   localparam int IDX_W = (BALLS > 1) ? $clog2(BALLS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BALLS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [5:0]       wt_q;
   ball_t            ball_q [BALLS];
   logic [1:0]       speed [BALLS];
   ball_t            work_q;
   logic [1:0]       work_speed_q;
   ball_t            step_d;
   logic             overrun_q;
   logic             start, fetch, commit, last;

   logic [7:0] step_x, step_y;
   logic       step_dir_x, step_dir_y;
   logic [1:0] step_div;

   for (genvar g = 0; g < BALLS; g++) begin : g_ball
      assign speed[g]          = speed_of(g);
      assign ball_x[8*g +: 8]  = ball_q[g].x;
      assign ball_y[8*g +: 8]  = ball_q[g].y;
   end

   assign last       = (idx_q == LAST_IDX);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign overrun    = overrun_q;

   ball_step u_step (
      .x          (work_q.x),
      .y          (work_q.y),
      .dir_x      (work_q.dir_x),
      .dir_y      (work_q.dir_y),
      .speed      (work_speed_q),
      .div        (work_q.div),
      .wt         (wt_q),
      .next_x     (step_x),
      .next_y     (step_y),
      .next_dir_x (step_dir_x),
      .next_dir_y (step_dir_y),
      .next_div   (step_div)
   );

   assign step_d = '{x: step_x, y: step_y, dir_x: step_dir_x,
                     dir_y: step_dir_y, div: step_div};

   // Scan sequencing: next state plus one-hot control strobes.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      fetch   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start && run) begin
               start   = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            fetch   = 1'b1;
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            commit  = 1'b1;
            state_d = last ? S_DONE : S_FETCH;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state, scan index, latched wall thickness, working copy, overrun.
   // NOTE: state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         wt_q         <= '0;
         work_q       <= '0;
         work_speed_q <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start) begin
            idx_q <= '0;
            wt_q  <= wall_thickness_4;
         end else if (commit && !last) begin
            idx_q <= idx_q + 1'b1;
         end
         if (fetch) begin
            work_q       <= ball_q[idx_q];
            work_speed_q <= speed[idx_q];
         end
         if (frame_start && (state_q != S_IDLE)) overrun_q <= 1'b1;
      end
   end

   // Ball state: start formation on reset, one ball written back per COMMIT.
   // NOTE: this array is a handful of flops, not a RAM, so it is reset like any other state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < BALLS; i++) ball_q[i] <= ball_reset(BALLS, i);
      end else if (commit) begin
         for (int i = 0; i < BALLS; i++) begin
            if (idx_q == IDX_W'(i)) ball_q[i] <= step_d;
         end
      end
   end

endmodule

// File: tb/tb_ball_scheduler.sv
// Self-checking bench for ball_scheduler: directed frames from the test plan,
// randomized frames and gaps, all compared against a behavioural ball model.
module tb_ball_scheduler;

   localparam int BALLS = 4;
   localparam int NX    = 160;
   localparam int NY    = 120;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 frame_start = 1'b0;
   logic                 run = 1'b0;
   logic [5:0]           wall_thickness_4 = '0;
   logic [8*BALLS-1:0]   ball_x, ball_y;
   logic                 busy, frame_done, overrun;

   int checks = 0;
   int errors = 0;

   // Behavioural model: per-ball state as plain integers.
   int mx [BALLS], my [BALLS], mdx [BALLS], mdy [BALLS], msp [BALLS], mdiv [BALLS];
   int ox [BALLS], oy [BALLS];
   bit m_ovr;

   always #5 clk = ~clk;

   ball_scheduler #(.BALLS(BALLS)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .frame_start      (frame_start),
      .run              (run),
      .wall_thickness_4 (wall_thickness_4),
      .ball_x           (ball_x),
      .ball_y           (ball_y),
      .busy             (busy),
      .frame_done       (frame_done),
      .overrun          (overrun)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < BALLS; i++) begin
         mx[i]   = NX / 2 - BALLS + 2 * i;
         my[i]   = NY / 2;
         mdx[i]  = (i / 2) % 2;
         mdy[i]  = i % 2;
         msp[i]  = i % 4;
         mdiv[i] = 0;
         ox[i]   = mx[i];
         oy[i]   = my[i];
      end
      m_ovr = 1'b0;
   endfunction

   // One frame of the game rules applied to every ball.
   function automatic void model_frame(int wt);
      for (int i = 0; i < BALLS; i++) begin
         ox[i] = mx[i];
         oy[i] = my[i];
         if (mdiv[i] != msp[i]) begin
            mdiv[i]++;
         end else begin
            mdiv[i] = 0;
            if (mdy[i] == 0 && my[i] <= wt)               mdy[i] = 1;
            else if (mdy[i] == 1 && my[i] >= NY - wt - 1) mdy[i] = 0;
            if (mdx[i] == 0 && mx[i] <= wt)               mdx[i] = 1;
            else if (mdx[i] == 1 && mx[i] >= NX - wt - 1) mdx[i] = 0;
            mx[i] += (mdx[i] == 1) ? 1 : -1;
            my[i] += (mdy[i] == 1) ? 1 : -1;
         end
      end
   endfunction

   // Expected coordinate bus k edges after E0: ball i is new once E(2i+2) has passed.
   function automatic logic [8*BALLS-1:0] pack_mix(int k, bit is_x);
      logic [8*BALLS-1:0] r;
      int v;
      for (int i = 0; i < BALLS; i++) begin
         if (2 * i + 2 <= k) v = is_x ? mx[i] : my[i];
         else                v = is_x ? ox[i] : oy[i];
         r[8*i +: 8] = 8'(v);
      end
      return r;
   endfunction

   // Run one accepted frame and check outputs every cycle of the scan.
   task automatic frame_scan(input int wt, input bit inject, input string tag);
      @(negedge clk);
      frame_start      = 1'b1;
      run              = 1'b1;
      wall_thickness_4 = 6'(wt);
      model_frame(wt);
      @(negedge clk);
      frame_start = 1'b0;
      for (int k = 0; k <= 2 * BALLS + 2; k++) begin
         if (inject && k == 3) m_ovr = 1'b1;
         check({tag, "_busy"}, 64'(busy), 64'(k <= 2 * BALLS));
         check({tag, "_done"}, 64'(frame_done), 64'(k == 2 * BALLS));
         check({tag, "_x"}, 64'(ball_x), 64'(pack_mix(k, 1'b1)));
         check({tag, "_y"}, 64'(ball_y), 64'(pack_mix(k, 1'b0)));
         check({tag, "_ovr"}, 64'(overrun), 64'(m_ovr));
         if (k == 1) begin
            run              = 1'($urandom);
            wall_thickness_4 = 6'($urandom);
         end
         frame_start = (inject && k == 2);
         @(negedge clk);
      end
      run = 1'b1;
   endtask

   // frame_start with run low must leave everything untouched.
   task automatic idle_pulse(input string tag);
      @(negedge clk);
      frame_start      = 1'b1;
      run              = 1'b0;
      wall_thickness_4 = 6'($urandom);
      @(negedge clk);
      frame_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check({tag, "_busy"}, 64'(busy), 64'd0);
         check({tag, "_done"}, 64'(frame_done), 64'd0);
         check({tag, "_x"}, 64'(ball_x), 64'(pack_mix(1000, 1'b1)));
         check({tag, "_y"}, 64'(ball_y), 64'(pack_mix(1000, 1'b0)));
         @(negedge clk);
      end
      run = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset state against the start formation constants.
      check("rst_x", 64'(ball_x), 64'h52504E4C);
      check("rst_y", 64'(ball_y), 64'h3C3C3C3C);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_ovr", 64'(overrun), 64'd0);

      // First frames, wt = 1.
      frame_scan(1, 1'b0, "f1");
      check("f1_b0x", 64'(ball_x[7:0]), 64'd75);
      check("f1_b0y", 64'(ball_y[7:0]), 64'd59);
      check("f1_b1x", 64'(ball_x[15:8]), 64'd78);
      check("f1_b1y", 64'(ball_y[15:8]), 64'd60);
      frame_scan(1, 1'b0, "f2");
      check("f2_b1x", 64'(ball_x[15:8]), 64'd77);
      check("f2_b1y", 64'(ball_y[15:8]), 64'd61);
      check("f2_b2x", 64'(ball_x[23:16]), 64'd80);
      frame_scan(1, 1'b0, "f3");
      check("f3_b3x", 64'(ball_x[31:24]), 64'd82);
      frame_scan(1, 1'b0, "f4");
      check("f4_b3x", 64'(ball_x[31:24]), 64'd83);
      check("f4_b3y", 64'(ball_y[31:24]), 64'd61);

      // Run ball0 into the top wall.
      for (int f = 5; f <= 61; f++) begin
         frame_scan(1, 1'b0, "fb");
         if (f == 59) begin
            check("f59_b0x", 64'(ball_x[7:0]), 64'd17);
            check("f59_b0y", 64'(ball_y[7:0]), 64'd1);
         end
         if (f == 60) begin
            check("f60_b0x", 64'(ball_x[7:0]), 64'd16);
            check("f60_b0y", 64'(ball_y[7:0]), 64'd2);
         end
         if (f == 61) check("f61_b0y", 64'(ball_y[7:0]), 64'd3);
      end

      idle_pulse("norun");

      // frame_start arriving mid-scan: ignored, overrun latches.
      frame_scan(1, 1'b1, "ovr");
      frame_scan(2, 1'b0, "ovr_hold");

      // Randomized frames, thicknesses and gaps.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) idle_pulse("rnd_norun");
         else frame_scan(int'($urandom_range(0, 63)), 1'b0, "rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check("rnd_ovr", 64'(overrun), 64'd1);

      // Reset asserted at E4 discards the partial scan.
      @(negedge clk);
      frame_start      = 1'b1;
      run              = 1'b1;
      wall_thickness_4 = 6'd1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("mid_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      check("arst_x", 64'(ball_x), 64'h52504E4C);
      check("arst_y", 64'(ball_y), 64'h3C3C3C3C);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(frame_done), 64'd0);
      check("arst_ovr", 64'(overrun), 64'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      frame_scan(1, 1'b0, "post_rst");
      check("post_b0x", 64'(ball_x[7:0]), 64'd75);
      check("post_b0y", 64'(ball_y[7:0]), 64'd59);
      check("post_b1x", 64'(ball_x[15:8]), 64'd78);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
